// File: rtl/inst_mem_responder_pkg.sv
// inst_mem_responder_pkg: shared word width, latency bound and FSM state encodings (IDLE/WAIT/RESPOND/HOLD)
package inst_mem_responder_pkg;
  localparam int WORD_SIZE = 16;
  localparam int LAT_MAX = 15;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;
endpackage

// File: rtl/inst_mem_responder_if.sv
// inst_mem_responder_if: CPU fetch handshake; master (CPU) drives readM/address, slave (memory) drives data/inputReady
interface inst_mem_responder_if;
  import inst_mem_responder_pkg::*;
  logic readM;
  logic [WORD_SIZE-1:0] address;
  logic [WORD_SIZE-1:0] data;
  logic inputReady;
  modport master (output readM, address, input data, inputReady);
  modport slave (input readM, address, output data, inputReady);
endinterface

// File: rtl/inst_mem_responder_word_ram.sv
// word_ram: 2^AB x W store, ports clk, we_i/waddr_i/wdata_i sync write, raddr_i->rdata_o combinational read, no reset
module word_ram #(
  parameter int W = 16,
  parameter int AB = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AB-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AB-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [2**AB];
  always_ff @(posedge clk)
    if (we_i) mem[waddr_i] <= wdata_i;
  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: latency-delayed fetch responder, ports clk/reset, bus (slave handshake), load_en/load_addr/load_data preload, busy, num_req
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  inst_mem_responder_if.slave  bus,
  input  logic                 load_en,
  input  logic [WORD_SIZE-1:0] load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] num_req
);
  if (LATENCY < 0 || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("inst_mem_responder: LATENCY out of range");
  end
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [WORD_SIZE-1:0] data_q, data_d, num_q, num_d, rd;
  logic rdy_q, rdy_d;
  logic unused_hi;
  word_ram #(.W(WORD_SIZE), .AB(ADDR_BITS)) u_ram (
    .clk(clk),
    .we_i(load_en),
    .waddr_i(load_addr[ADDR_BITS-1:0]),
    .wdata_i(load_data),
    .raddr_i(idx_q),
    .rdata_o(rd)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    data_d = data_q;
    rdy_d = rdy_q;
    num_d = num_q;
    case (state_q)
      S_IDLE: if (bus.readM) begin
        idx_d = bus.address[ADDR_BITS-1:0];
        cnt_d = 4'(LATENCY);
        state_d = LATENCY > 0 ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? S_RESP : S_WAIT;
      end
      S_RESP: begin
        rdy_d = !rdy_q;
        data_d = rdy_q ? data_q : rd;
        num_d = rdy_q ? num_q + WORD_SIZE'(1) : num_q;
        state_d = rdy_q ? S_HOLD : S_RESP;
      end
      default: state_d = bus.readM ? S_HOLD : S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      rdy_q <= 1'b0;
      num_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      data_q <= data_d;
      rdy_q <= rdy_d;
      num_q <= num_d;
    end
  end
  assign bus.data = data_q;
  assign bus.inputReady = rdy_q;
  assign busy = state_q != S_IDLE;
  assign num_req = num_q;
  assign unused_hi = ^{bus.address[WORD_SIZE-1:ADDR_BITS], load_addr[WORD_SIZE-1:ADDR_BITS]};
endmodule

// File: tb/tb_inst_mem_responder.sv
// tb_inst_mem_responder: randomized self-checking bench for two responders (LATENCY=0 and LATENCY=2)
module tb_inst_mem_responder;
  import inst_mem_responder_pkg::*;
  logic clk, reset;
  logic rm [2];
  logic [15:0] ad [2];
  logic le [2];
  logic [15:0] la [2], ld [2];
  logic bz [2];
  logic [15:0] nr [2];
  logic [15:0] m [2][256];
  int nexp [2];
  int tests, fails, edge_n;
  inst_mem_responder_if if0 ();
  inst_mem_responder_if if2 ();
  assign if0.readM = rm[0];
  assign if0.address = ad[0];
  assign if2.readM = rm[1];
  assign if2.address = ad[1];
  inst_mem_responder #(.ADDR_BITS(8), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .bus(if0), .load_en(le[0]), .load_addr(la[0]),
    .load_data(ld[0]), .busy(bz[0]), .num_req(nr[0]));
  inst_mem_responder #(.ADDR_BITS(8), .LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .bus(if2), .load_en(le[1]), .load_addr(la[1]),
    .load_data(ld[1]), .busy(bz[1]), .num_req(nr[1]));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) edge_n <= edge_n + 1;
  function automatic logic rdy_of(int s);
    return s != 0 ? if2.inputReady : if0.inputReady;
  endfunction
  function automatic logic [15:0] dat_of(int s);
    return s != 0 ? if2.data : if0.data;
  endfunction
  function automatic int lat_exp(int s);
    return s != 0 ? 3 : 1;
  endfunction
  task automatic preload(input int s, input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    le[s] = 1; la[s] = a; ld[s] = v;
    @(negedge clk);
    le[s] = 0;
    m[s][a[7:0]] = v;
  endtask
  task automatic do_req(input int s, input logic [15:0] a, input int hold, output int lat,
                        output int pulses, output logic [15:0] d, output bit busy_ok, output int idle_n);
    int acc, rise;
    bit seen;
    logic [31:0] r;
    seen = 0; pulses = 0; busy_ok = 1; rise = -1000; d = 'x; idle_n = -1;
    @(negedge clk);
    rm[s] = 1; ad[s] = a; acc = edge_n + 1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      r = $urandom;
      ad[s] = r[15:0];
      if (rdy_of(s)) begin seen = 1; rise = edge_n; d = dat_of(s); pulses++; end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rdy_of(s)) pulses++;
      if (!bz[s]) busy_ok = 0;
    end
    rm[s] = 0;
    for (int i = 1; i <= 6 && idle_n < 0; i++) begin
      @(negedge clk);
      if (rdy_of(s)) pulses++;
      if (!bz[s]) idle_n = i;
    end
    lat = rise - acc;
    if (seen) nexp[s] = (nexp[s] + 1) & 16'hFFFF;
  endtask
  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      tests++; if (rdy_of(s) !== 1'b0) begin fails++; $display("FAIL reset_rdy[%0d]: got %b exp 0", s, rdy_of(s)); end
      tests++; if (dat_of(s) !== 16'h0) begin fails++; $display("FAIL reset_data[%0d]: got %h exp 0000", s, dat_of(s)); end
      tests++; if (nr[s] !== 16'h0) begin fails++; $display("FAIL reset_num[%0d]: got %h exp 0000", s, nr[s]); end
      tests++; if (bz[s] !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b exp 0", s, bz[s]); end
      nexp[s] = 0;
    end
    reset = 0;
  endtask
  task automatic test_latency;
    int lat, p, idl; logic [15:0] d; bit bok;
    preload(1, 16'h0005, 16'hA5A5);
    preload(0, 16'h0005, 16'hA5A5);
    do_req(1, 16'h0005, 0, lat, p, d, bok, idl);
    tests++; if (lat !== lat_exp(1)) begin fails++; $display("FAIL lat2_latency: got %0d exp %0d", lat, lat_exp(1)); end
    tests++; if (p !== 1) begin fails++; $display("FAIL lat2_pulses: got %0d exp 1", p); end
    tests++; if (d !== 16'hA5A5) begin fails++; $display("FAIL lat2_data: got %h exp a5a5", d); end
    tests++; if (nr[1] !== 16'd1) begin fails++; $display("FAIL lat2_num: got %0d exp 1", nr[1]); end
  endtask
  task automatic test_wrap;
    int lat, p, idl; logic [15:0] d, v; bit bok;
    v = 16'($urandom);
    preload(0, 16'h00FF, v);
    do_req(0, 16'hFFFF, 0, lat, p, d, bok, idl);
    tests++; if (lat !== lat_exp(0)) begin fails++; $display("FAIL wrap_latency: got %0d exp %0d", lat, lat_exp(0)); end
    tests++; if (d !== v) begin fails++; $display("FAIL wrap_data: got %h exp %h", d, v); end
    tests++; if (p !== 1) begin fails++; $display("FAIL wrap_pulses: got %0d exp 1", p); end
    tests++; if (nr[0] !== 16'(nexp[0])) begin fails++; $display("FAIL wrap_num: got %0d exp %0d", nr[0], nexp[0]); end
  endtask
  task automatic test_hold;
    int lat, p, idl; logic [15:0] d; bit bok;
    do_req(1, 16'h0005, 6, lat, p, d, bok, idl);
    tests++; if (p !== 1) begin fails++; $display("FAIL hold_pulses: got %0d exp 1", p); end
    tests++; if (bok !== 1'b1) begin fails++; $display("FAIL hold_busy: got %b exp 1", bok); end
    tests++; if (idl !== 1) begin fails++; $display("FAIL hold_idle_delay: got %0d exp 1", idl); end
    tests++; if (d !== 16'hA5A5) begin fails++; $display("FAIL hold_data: got %h exp a5a5", d); end
  endtask
  task automatic test_reset_wait;
    int lat, p, idl, seen; logic [15:0] d; bit bok;
    seen = 0;
    @(negedge clk);
    rm[1] = 1; ad[1] = 16'h0005;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0; rm[1] = 0;
    nexp[0] = 0; nexp[1] = 0;
    repeat (6) begin @(negedge clk); if (rdy_of(1)) seen++; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL rstwait_pulses: got %0d exp 0", seen); end
    tests++; if (dat_of(1) !== 16'h0) begin fails++; $display("FAIL rstwait_data: got %h exp 0000", dat_of(1)); end
    tests++; if (nr[1] !== 16'h0) begin fails++; $display("FAIL rstwait_num: got %0d exp 0", nr[1]); end
    tests++; if (bz[1] !== 1'b0) begin fails++; $display("FAIL rstwait_busy: got %b exp 0", bz[1]); end
    do_req(1, 16'h0005, 0, lat, p, d, bok, idl);
    tests++; if (d !== m[1][5]) begin fails++; $display("FAIL rstwait_retained: got %h exp %h", d, m[1][5]); end
    tests++; if (lat !== lat_exp(1)) begin fails++; $display("FAIL rstwait_latency: got %0d exp %0d", lat, lat_exp(1)); end
  endtask
  task automatic test_rbw;
    int lat, p, idl, acc; logic [15:0] d; bit bok;
    preload(1, 16'h0007, 16'h0BAD);
    @(negedge clk);
    rm[1] = 1; ad[1] = 16'h0007; acc = edge_n + 1;
    for (int i = 0; i < 10 && edge_n != acc + 2; i++) @(negedge clk);
    le[1] = 1; la[1] = 16'h0007; ld[1] = 16'h1234;
    @(negedge clk);
    le[1] = 0;
    tests++; if (rdy_of(1) !== 1'b1) begin fails++; $display("FAIL rbw_rdy: got %b exp 1", rdy_of(1)); end
    tests++; if (dat_of(1) !== 16'h0BAD) begin fails++; $display("FAIL rbw_old: got %h exp 0bad", dat_of(1)); end
    m[1][7] = 16'h1234;
    nexp[1]++;
    rm[1] = 0;
    for (int i = 0; i < 6 && bz[1]; i++) @(negedge clk);
    do_req(1, 16'h0007, 0, lat, p, d, bok, idl);
    tests++; if (d !== 16'h1234) begin fails++; $display("FAIL rbw_new: got %h exp 1234", d); end
    tests++; if (nr[1] !== 16'(nexp[1])) begin fails++; $display("FAIL rbw_num: got %0d exp %0d", nr[1], nexp[1]); end
  endtask
  task automatic test_back_to_back;
    int lat, p, idl, base, n0; logic [15:0] d; bit bok;
    base = $urandom_range(8'h80, 8'hF0);
    for (int i = 0; i < 4; i++) preload(1, 16'(base + i), 16'($urandom));
    n0 = nexp[1];
    for (int i = 0; i < 4; i++) begin
      do_req(1, 16'(base + i), 0, lat, p, d, bok, idl);
      tests++; if (d !== m[1][base + i]) begin fails++; $display("FAIL b2b_data[%0d]: got %h exp %h", i, d, m[1][base + i]); end
      tests++; if (p !== 1) begin fails++; $display("FAIL b2b_pulses[%0d]: got %0d exp 1", i, p); end
      tests++; if (lat !== lat_exp(1)) begin fails++; $display("FAIL b2b_latency[%0d]: got %0d exp %0d", i, lat, lat_exp(1)); end
    end
    tests++; if (nr[1] !== 16'(n0 + 4)) begin fails++; $display("FAIL b2b_num: got %0d exp %0d", nr[1], n0 + 4); end
  endtask
  task automatic test_random;
    int lat, p, idl, s; logic [15:0] d, a; logic [31:0] r; bit bok;
    for (int s2 = 0; s2 < 2; s2++)
      for (int i = 0; i < 16; i++) preload(s2, 16'(8'h40 + i), 16'($urandom));
    for (int k = 0; k < 20; k++) begin
      s = $urandom_range(0, 1);
      r = $urandom;
      a = {r[15:8], 4'h4, r[3:0]};
      if (r[20]) preload(s, {r[31:24], a[7:0]}, r[31:16] ^ 16'h5A5A);
      do_req(s, a, $urandom_range(0, 3), lat, p, d, bok, idl);
      tests++; if (d !== m[s][a[7:0]]) begin fails++; $display("FAIL rnd_data[%0d]: got %h exp %h", k, d, m[s][a[7:0]]); end
      tests++; if (lat !== lat_exp(s)) begin fails++; $display("FAIL rnd_latency[%0d]: got %0d exp %0d", k, lat, lat_exp(s)); end
      tests++; if (p !== 1) begin fails++; $display("FAIL rnd_pulses[%0d]: got %0d exp 1", k, p); end
      tests++; if (nr[s] !== 16'(nexp[s])) begin fails++; $display("FAIL rnd_num[%0d]: got %0d exp %0d", k, nr[s], nexp[s]); end
    end
  endtask
  initial begin
    tests = 0; fails = 0; edge_n = 0; reset = 1;
    for (int s = 0; s < 2; s++) begin rm[s] = 0; ad[s] = 0; le[s] = 0; la[s] = 0; ld[s] = 0; nexp[s] = 0; end
    test_reset;
    test_latency;
    test_wrap;
    test_hold;
    test_reset_wait;
    test_rbw;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
